// File: rtl/decode_ctrl.sv
// decode_ctrl: single-entry decode stage with load-use bubble, flush and backpressure.
// Optional DECODE_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module decode_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] instr_reg_fetch,
    input  logic [31:0] pc_fetch,
    input  logic        ex_ready,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic        dec_valid,
    output logic [31:0] instr_decode,
    output logic [31:0] pc_decode,
    output logic [2:0]  imm_sel,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        dec_illegal
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, VALID, HAZARD} state_t;
    state_t state, state_n;
    logic hz_done, hz_done_n, hazard, capture, is_s, is_b, known;
    logic [6:0] opcode;

    assign opcode = instr_decode[6:0];
    assign is_s = opcode == 7'b0100011;
    assign is_b = opcode == 7'b1100011;
    assign rs1 = instr_decode[19:15];
    assign rs2 = instr_decode[24:20];
    assign rd = (is_s || is_b) ? 5'd0 : instr_decode[11:7];
    assign imm_sel = opcode == 7'b0010011 ? 3'd1 :
                     is_s                 ? 3'd2 :
                     is_b                 ? 3'd3 :
                     opcode == 7'b0000011 ? 3'd4 : 3'd0;
    assign known = opcode == 7'b0110011 || opcode == 7'b0010011 || opcode == 7'b0000011 || is_s || is_b;
    assign dec_illegal = state == VALID && !known;
    // hz_done masks the hazard once the single bubble has been inserted
    assign hazard = ex_is_load && ex_rd != 5'd0 &&
                    (ex_rd == rs1 || ((is_s || is_b) && ex_rd == rs2)) && !hz_done;

    always_comb begin
        state_n = state;
        hz_done_n = hz_done;
        capture = 1'b0;
        fetch_ready = 1'b0;
        dec_valid = 1'b0;
        case (state)
            IDLE: begin
                fetch_ready = 1'b1;
                if (fetch_valid) begin
                    capture = 1'b1;
                    state_n = VALID;
                end
            end
            VALID: begin
                fetch_ready = ex_ready && !hazard;
                dec_valid = !hazard;
                if (hazard) state_n = HAZARD;
                else if (ex_ready && fetch_valid) capture = 1'b1;
                else if (ex_ready) state_n = IDLE;
            end
            HAZARD: begin
                state_n = VALID;
                hz_done_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (capture) hz_done_n = 1'b0;
        if (flush) begin
            state_n = IDLE;
            hz_done_n = 1'b0;
            capture = 1'b0;
            fetch_ready = 1'b0;
            dec_valid = 1'b0;
        end
        if (!rst) begin
            fetch_ready = 1'b0;
            dec_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            hz_done <= 1'b0;
            instr_decode <= '0;
            pc_decode <= '0;
        end else begin
            state <= state_n;
            hz_done <= hz_done_n;
            if (capture) begin
                instr_decode <= instr_reg_fetch;
                pc_decode <= pc_fetch;
            end
        end
    end

`ifdef DECODE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == HAZARD && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (flush && state == VALID && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: directed stimulus with a scoreboard queue checked by a decoupled output monitor.
module tb_decode_ctrl;
    logic        clk = 1'b0;
    logic        rst, fetch_valid, fetch_ready, ex_ready, ex_is_load, flush, dec_valid, dec_illegal;
    logic [31:0] instr_reg_fetch, pc_fetch, instr_decode, pc_decode;
    logic [4:0]  ex_rd, rs1, rs2, rd;
    logic [2:0]  imm_sel;
`ifdef DECODE_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    decode_ctrl dut (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .instr_reg_fetch(instr_reg_fetch), .pc_fetch(pc_fetch), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush), .dec_valid(dec_valid),
        .instr_decode(instr_decode), .pc_decode(pc_decode), .imm_sel(imm_sel),
        .rs1(rs1), .rs2(rs2), .rd(rd), .dec_illegal(dec_illegal)
`ifdef DECODE_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t tbl [7];
    exp_t q [$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int i, input bit push);
        fetch_valid = 1'b1;
        instr_reg_fetch = tbl[i].instr;
        pc_fetch = tbl[i].pc;
        if (push) q.push_back(tbl[i]);
    endtask

    always @(negedge clk) begin
        if (rst && dec_valid && ex_ready) begin
            if (q.size() == 0) chk("unexpected_out", dec_valid, 1'b0);
            else begin
                automatic exp_t e = q.pop_front();
                chk("instr_decode", instr_decode, e.instr);
                chk("pc_decode", pc_decode, e.pc);
                chk("imm_sel", imm_sel, e.imm);
                chk("rs1", rs1, e.rs1);
                chk("rs2", rs2, e.rs2);
                chk("rd", rd, e.rd);
                chk("dec_illegal", dec_illegal, e.ill);
            end
        end
    end

    initial begin
        tbl[0] = '{32'h00510093, 32'h100, 3'd1, 5'd2,  5'd5, 5'd1,  1'b0};
        tbl[1] = '{32'h00322423, 32'h104, 3'd2, 5'd4,  5'd3, 5'd0,  1'b0};
        tbl[2] = '{32'h00730063, 32'h108, 3'd3, 5'd6,  5'd7, 5'd0,  1'b0};
        tbl[3] = '{32'h00928433, 32'h10C, 3'd0, 5'd5,  5'd9, 5'd8,  1'b0};
        tbl[4] = '{32'h00100093, 32'h110, 3'd1, 5'd0,  5'd1, 5'd1,  1'b0};
        tbl[5] = '{32'h0005A503, 32'h200, 3'd4, 5'd11, 5'd0, 5'd10, 1'b0};
        tbl[6] = '{32'h000000EF, 32'h204, 3'd0, 5'd0,  5'd0, 5'd1,  1'b1};
        rst = 1'b0; fetch_valid = 1'b0; instr_reg_fetch = '0; pc_fetch = '0;
        ex_ready = 1'b0; ex_is_load = 1'b0; ex_rd = '0; flush = 1'b0;
        step(); step();
        @(negedge clk);
        chk("rst_fetch_ready", fetch_ready, 1'b0);
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_instr", instr_decode, 32'h0);
        chk("rst_pc", pc_decode, 32'h0);
        chk("rst_imm_sel", imm_sel, 3'd0);
        chk("rst_regs", {rs1, rs2, rd}, 15'h0);
        chk("rst_illegal", dec_illegal, 1'b0);
        step(); rst = 1'b1;
        @(negedge clk);
        chk("idle_fetch_ready", fetch_ready, 1'b1);
        // back-to-back streaming
        step(); ex_ready = 1'b1; offer(0, 1);
        @(negedge clk); chk("stream_c1_valid", dec_valid, 1'b0);
        step(); offer(1, 1);
        @(negedge clk); chk("stream_c2_valid", dec_valid, 1'b1); chk("stream_c2_ready", fetch_ready, 1'b1);
        step(); offer(2, 1);
        @(negedge clk); chk("stream_c3_valid", dec_valid, 1'b1);
        step(); fetch_valid = 1'b0;
        @(negedge clk); chk("stream_c4_valid", dec_valid, 1'b1);
        step();
        @(negedge clk); chk("stream_idle_valid", dec_valid, 1'b0);
        // load-use with a matching rs1
        step(); offer(3, 1); ex_is_load = 1'b1; ex_rd = 5'd5;
        step(); fetch_valid = 1'b0;
        @(negedge clk); chk("lu_hazard_valid", dec_valid, 1'b0); chk("lu_hazard_ready", fetch_ready, 1'b0);
        step();
        @(negedge clk); chk("lu_bubble_valid", dec_valid, 1'b0);
        step();
        @(negedge clk); chk("lu_resume_valid", dec_valid, 1'b1);
        // ex_rd = 0 never stalls
        step(); ex_rd = 5'd0; offer(4, 1);
        step(); fetch_valid = 1'b0;
        @(negedge clk); chk("lu_x0_valid", dec_valid, 1'b1);
        // backpressure
        step(); ex_is_load = 1'b0; offer(5, 1);
        step(); ex_ready = 1'b0; offer(6, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", dec_valid, 1'b1);
            chk("bp_ready", fetch_ready, 1'b0);
            chk("bp_instr", instr_decode, 32'h0005A503);
            chk("bp_pc", pc_decode, 32'h200);
            step();
        end
        ex_ready = 1'b1;
        @(negedge clk); chk("bp_release_ready", fetch_ready, 1'b1);
        step(); fetch_valid = 1'b0;
        @(negedge clk); chk("illegal_valid", dec_illegal, 1'b1); chk("illegal_imm", imm_sel, 3'd0);
        step();
        @(negedge clk); chk("illegal_idle", dec_illegal, 1'b0);
        // flush concurrent with a fetch offer; neither instruction may leave
        step(); ex_ready = 1'b0; offer(0, 0);
        step(); flush = 1'b1; offer(1, 0);
        @(negedge clk); chk("flush_valid", dec_valid, 1'b0); chk("flush_ready", fetch_ready, 1'b0);
        step(); flush = 1'b0; fetch_valid = 1'b0; ex_ready = 1'b1;
        @(negedge clk); chk("post_flush_valid", dec_valid, 1'b0); chk("post_flush_idle", fetch_ready, 1'b1);
`ifdef DECODE_PERF_CNT_EN
        chk("flush_cnt", flush_cnt, 16'd1);
        chk("stall_cnt", stall_cnt, 16'd1);
`endif
        step(); step();
        // reset asserted while holding an instruction
        ex_ready = 1'b0; offer(2, 0);
        step(); fetch_valid = 1'b0; rst = 1'b0; ex_ready = 1'b1;
        @(negedge clk); chk("rst_mid_valid", dec_valid, 1'b0); chk("rst_mid_ready", fetch_ready, 1'b0);
        step(); rst = 1'b1;
        @(negedge clk);
        chk("rst2_valid", dec_valid, 1'b0);
        chk("rst2_instr", instr_decode, 32'h0);
        chk("rst2_pc", pc_decode, 32'h0);
        chk("rst2_imm_sel", imm_sel, 3'd0);
        chk("rst2_regs", {rs1, rs2, rd}, 15'h0);
        chk("rst2_illegal", dec_illegal, 1'b0);
        chk("rst2_ready", fetch_ready, 1'b1);
`ifdef DECODE_PERF_CNT_EN
        chk("rst2_cnts", {stall_cnt, flush_cnt}, 32'h0);
`endif
        step(); step();
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous active-low reset, listed first: clk input 1, rising-edge clock; rst input 1, synchronous active-low reset.
REQ-002 SHALL have these fetch-side ports:
- fetch_valid input 1: fetch offers an instruction.
- fetch_ready output 1: decode accepts this cycle.
- instr_reg_fetch input 32: fetched instruction.
- pc_fetch input 32: its PC.
REQ-003 SHALL have these execute-side ports:
- ex_ready input 1: execute accepts.
- ex_is_load input 1: the instruction in execute is a load.
- ex_rd input 5: its destination register.
- flush input 1: redirect from execute.
REQ-004 SHALL have these outputs: dec_valid 1; instr_decode 32; pc_decode 32; imm_sel 3, immediate-format select; rs1, rs2, rd 5 each; dec_illegal 1, unsupported opcode.

Function
REQ-005 SHALL implement FSM states IDLE (empty), VALID (holding an instruction), HAZARD (one-cycle bubble).
REQ-006 SHALL define a transfer in as fetch_valid & fetch_ready, and a transfer out as dec_valid & ex_ready.
REQ-007 SHALL drive fetch_ready = 1 in IDLE, = ex_ready & !hazard in VALID, and = 0 in HAZARD or whenever flush = 1.
REQ-008 SHALL drive dec_valid = 1 only in VALID with hazard = 0 and flush = 0.
REQ-009 SHALL compute hazard = ex_is_load & (ex_rd != 0) & (ex_rd == rs1 | (opcode in {S, B} & ex_rd == rs2)) & !hz_done.
REQ-010 SHALL take these IDLE transitions: on a transfer in, capture instr/pc and go to VALID; otherwise stay in IDLE.
REQ-011 SHALL take these VALID transitions: if hazard, go to HAZARD; if a transfer out and a transfer in occur together, capture the new instruction and stay in VALID (back-to-back, zero bubble); if only a transfer out occurs, go to IDLE; otherwise hold.
REQ-012 SHALL go from HAZARD to VALID unconditionally after exactly one cycle, with hz_done set; hz_done SHALL clear on every new capture.
REQ-013 SHALL give flush top priority: next state IDLE, held instruction discarded, hz_done cleared, and any fetch offered in the flush cycle dropped.
REQ-014 SHALL register instr_decode and pc_decode (latency one cycle from a transfer in) and hold them stable while dec_valid = 1 and ex_ready = 0.
REQ-015 SHALL decode combinationally from instr_decode[6:0]:
- 0110011 -> imm_sel 0
- 0010011 -> 1
- 0100011 -> 2
- 1100011 -> 3
- 0000011 -> 4
- any other opcode -> imm_sel 0 and dec_illegal = 1 (only while in VALID).
REQ-016 SHALL drive rs1 = [19:15], rs2 = [24:20], rd = [11:7] from instr_decode, with rd forced to 0 for S and B.

Reset
REQ-017 SHALL, on rst = 0 at a clock edge, enter IDLE and zero instr_decode, pc_decode and hz_done; dec_valid, dec_illegal, imm_sel, rs1, rs2 and rd SHALL then read 0 and fetch_ready SHALL read 0 while rst = 0.
REQ-018 SHALL discard an in-flight instruction when reset is asserted mid-operation, with no transfer out in that cycle.

Configuration
REQ-019 SHALL, with DECODE_PERF_CNT_EN defined, add outputs stall_cnt 16 (cycles spent in HAZARD) and flush_cnt 16 (flushes that discard a VALID instruction), both saturating at 16'hFFFF and reset to 0.
REQ-020 SHALL, without DECODE_PERF_CNT_EN, omit these ports and counters with no other behaviour change.

Verification
REQ-021 SHALL cover back-to-back streaming: addi, sw, beq offered with ex_ready = 1 -> dec_valid every cycle from cycle 2, imm_sel 1, 2, 3, no bubbles.
REQ-022 SHALL cover load-use: ex_is_load = 1, ex_rd = 5, held instr rs1 = 5 -> one cycle dec_valid = 0 (HAZARD), then dec_valid = 1; with ex_rd = 0 -> no bubble.
REQ-023 SHALL cover backpressure: ex_ready = 0 for 3 cycles while VALID -> instr_decode and pc_decode unchanged, fetch_ready = 0, and the transfer occurs on the cycle ex_ready returns.
REQ-024 SHALL cover flush concurrent with fetch_valid = 1 in VALID -> next cycle IDLE, dec_valid = 0, offered instruction dropped, and flush_cnt +1 when DECODE_PERF_CNT_EN is defined.
REQ-025 SHALL cover illegal opcode 1101111 -> dec_illegal = 1 and imm_sel = 0; and rst = 0 asserted mid-VALID -> next cycle IDLE with all outputs 0.
